// File: rtl/health_ctrl_pkg.sv
// Shared types and default constants for the game-session health controller.
package health_ctrl_pkg;
    localparam int HEALTH_W = 7;
    localparam int RATE_W   = 27;
    localparam int LEVEL_W  = 4;
    localparam int SCORE_W  = 8;

    localparam logic [RATE_W-1:0]   DEF_BASE_RATE  = 27'd50_000_000;
    localparam logic [RATE_W-1:0]   DEF_RATE_STEP  = 27'd5_000_000;
    localparam logic [RATE_W-1:0]   DEF_MIN_RATE   = 27'd10_000_000;
    localparam int                  DEF_LEVEL_UP   = 5;
    localparam int                  DEF_MAX_LEVEL  = 9;
    localparam logic [HEALTH_W-1:0] DEF_MAX_HEALTH = 7'd99;

    typedef enum logic [1:0] {IDLE, CLEAR, PLAY, OVER} hc_state_t;
endpackage

// File: rtl/health_rate_calc.sv
// Combinational level-to-decay-period mapping with a floor at MIN_RATE.
module health_rate_calc
    import health_ctrl_pkg::*;
#(
    parameter logic [RATE_W-1:0] BASE_RATE = DEF_BASE_RATE,
    parameter logic [RATE_W-1:0] RATE_STEP = DEF_RATE_STEP,
    parameter logic [RATE_W-1:0] MIN_RATE  = DEF_MIN_RATE
) (
    input  logic [LEVEL_W-1:0] i_level,
    output logic [RATE_W-1:0]  o_rate
);
    logic signed [31:0] w_step_total;
    logic signed [31:0] w_diff;

    // Signed 32-bit arithmetic so BASE - level*STEP may go negative without wrapping.
    always_comb begin
        w_step_total = $signed({28'd0, i_level}) * $signed({5'd0, RATE_STEP});
        w_diff       = $signed({5'd0, BASE_RATE}) - w_step_total;
        if (w_diff < $signed({5'd0, MIN_RATE})) begin
            o_rate = MIN_RATE;
        end else begin
            o_rate = w_diff[RATE_W-1:0];
        end
    end
endmodule

// File: rtl/health_controller.sv
// Session FSM (IDLE/CLEAR/PLAY/OVER) that sequences the health block,
// turns correct answers into add_health pulses and tracks score/streak/level.
module health_controller
    import health_ctrl_pkg::*;
#(
    parameter logic [RATE_W-1:0]   BASE_RATE  = DEF_BASE_RATE,
    parameter logic [RATE_W-1:0]   RATE_STEP  = DEF_RATE_STEP,
    parameter logic [RATE_W-1:0]   MIN_RATE   = DEF_MIN_RATE,
    parameter int                  LEVEL_UP   = DEF_LEVEL_UP,
    parameter int                  MAX_LEVEL  = DEF_MAX_LEVEL,
    parameter logic [HEALTH_W-1:0] MAX_HEALTH = DEF_MAX_HEALTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                correct,
    input  logic                wrong,
    input  logic [HEALTH_W-1:0] current_health,
    input  logic                no_health,
    output logic                health_reset_n,
    output logic [RATE_W-1:0]   health_rate,
    output logic                add_health,
    output logic [SCORE_W-1:0]  score,
    output logic [LEVEL_W-1:0]  level,
    output logic                playing,
    output logic                game_over
);
    localparam int STREAK_W = $clog2(LEVEL_UP + 1);

    hc_state_t r_state;
    hc_state_t w_state_nxt;

    logic r_health_reset_n, r_add_health, r_playing, r_game_over;
    logic w_health_reset_n_nxt, w_add_health_nxt, w_playing_nxt, w_game_over_nxt;

    logic w_take_correct;
    logic w_take_wrong;

    logic [SCORE_W-1:0]  r_score;
    logic [LEVEL_W-1:0]  r_level;
    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_streak_inc;
    logic [RATE_W-1:0]   r_health_rate;
    logic [RATE_W-1:0]   w_rate;

    // no_health wins over any answer arriving in the same cycle.
    assign w_take_correct = (r_state == PLAY) && !no_health && correct && !wrong;
    assign w_take_wrong   = (r_state == PLAY) && !no_health && wrong && !correct;
    assign w_streak_inc   = r_streak + STREAK_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nxt = CLEAR;
            CLEAR:   w_state_nxt = PLAY;
            PLAY:    if (no_health) w_state_nxt = OVER;
            OVER:    if (start) w_state_nxt = CLEAR;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change on the same edge as the state.
    always_comb begin
        w_health_reset_n_nxt = (w_state_nxt == PLAY) || (w_state_nxt == OVER);
        w_playing_nxt        = (w_state_nxt == PLAY);
        w_game_over_nxt      = (w_state_nxt == OVER);
        w_add_health_nxt     = w_take_correct && (current_health < MAX_HEALTH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_health_reset_n <= 1'b0;
            r_add_health     <= 1'b0;
            r_playing        <= 1'b0;
            r_game_over      <= 1'b0;
        end else begin
            r_health_reset_n <= w_health_reset_n_nxt;
            r_add_health     <= w_add_health_nxt;
            r_playing        <= w_playing_nxt;
            r_game_over      <= w_game_over_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_score  <= '0;
            r_level  <= '0;
            r_streak <= '0;
        end else if (w_state_nxt == CLEAR) begin
            r_score  <= '0;
            r_level  <= '0;
            r_streak <= '0;
        end else if (w_take_correct) begin
            if (r_score != '1) begin
                r_score <= r_score + SCORE_W'(1);
            end
            if (w_streak_inc == STREAK_W'(LEVEL_UP)) begin
                r_streak <= '0;
                if (r_level < LEVEL_W'(MAX_LEVEL)) begin
                    r_level <= r_level + LEVEL_W'(1);
                end
            end else begin
                r_streak <= w_streak_inc;
            end
        end else if (w_take_wrong) begin
            r_streak <= '0;
        end
    end

    health_rate_calc #(
        .BASE_RATE (BASE_RATE),
        .RATE_STEP (RATE_STEP),
        .MIN_RATE  (MIN_RATE)
    ) u_rate_calc (
        .i_level (r_level),
        .o_rate  (w_rate)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_health_rate <= BASE_RATE;
        end else begin
            r_health_rate <= w_rate;
        end
    end

    assign health_reset_n = r_health_reset_n;
    assign health_rate    = r_health_rate;
    assign add_health     = r_add_health;
    assign score          = r_score;
    assign level          = r_level;
    assign playing        = r_playing;
    assign game_over      = r_game_over;
endmodule

// File: tb/tb_health_controller.sv
// Self-checking bench: directed session scenarios plus random play against a behavioural model.
module tb_health_controller;
    localparam int BASE = 100;
    localparam int STEP = 10;
    localparam int MINR = 40;
    localparam int LUP  = 2;
    localparam int MAXL = 9;
    localparam int MAXH = 22;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        correct = 1'b0;
    logic        wrong = 1'b0;
    logic        no_health = 1'b0;
    logic [6:0]  cur_health = 7'd10;

    logic        health_reset_n;
    logic [26:0] health_rate;
    logic        add_health;
    logic [7:0]  score;
    logic [3:0]  level;
    logic        playing;
    logic        game_over;

    int vectors = 0;
    int miscompares = 0;
    int add_cnt = 0;
    int base_cnt;

    // Model: phase 0 idle, 1 clear, 2 play, 3 over.
    int m_phase  = 0;
    int m_score  = 0;
    int m_level  = 0;
    int m_streak = 0;
    int m_rate   = BASE;
    bit m_add    = 1'b0;

    health_controller #(
        .BASE_RATE  (27'd100),
        .RATE_STEP  (27'd10),
        .MIN_RATE   (27'd40),
        .LEVEL_UP   (2),
        .MAX_LEVEL  (9),
        .MAX_HEALTH (7'd22)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .start          (start),
        .correct        (correct),
        .wrong          (wrong),
        .current_health (cur_health),
        .no_health      (no_health),
        .health_reset_n (health_reset_n),
        .health_rate    (health_rate),
        .add_health     (add_health),
        .score          (score),
        .level          (level),
        .playing        (playing),
        .game_over      (game_over)
    );

    always #5 clk = ~clk;

    function automatic int rate_of(input int lv);
        int r;
        r = BASE - lv * STEP;
        return (r < MINR) ? MINR : r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_score = 0; m_level = 0; m_streak = 0;
            m_rate = BASE; m_add = 1'b0;
        end else begin
            m_rate = rate_of(m_level);
            m_add  = 1'b0;
            case (m_phase)
                0, 3: if (start) begin
                    m_phase = 1; m_score = 0; m_level = 0; m_streak = 0;
                end
                1: m_phase = 2;
                default: begin
                    if (no_health) begin
                        m_phase = 3;
                    end else if (correct && !wrong) begin
                        m_score  = (m_score < 255) ? m_score + 1 : 255;
                        m_streak = m_streak + 1;
                        if (m_streak == LUP) begin
                            m_streak = 0;
                            m_level  = (m_level < MAXL) ? m_level + 1 : MAXL;
                        end
                        m_add = (int'(cur_health) < MAXH);
                    end else if (wrong && !correct) begin
                        m_streak = 0;
                    end
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (add_health === 1'b1) add_cnt++;
        check("health_reset_n", 32'(health_reset_n), 32'(m_phase >= 2));
        check("playing",        32'(playing),        32'(m_phase == 2));
        check("game_over",      32'(game_over),      32'(m_phase == 3));
        check("add_health",     32'(add_health),     32'(m_add));
        check("score",          32'(score),          32'(m_score));
        check("level",          32'(level),          32'(m_level));
        check("health_rate",    32'(health_rate),    32'(m_rate));
    end

    task automatic cyc(input bit s, input bit c, input bit w, input bit n, input int hp);
        @(negedge clk);
        start = s; correct = c; wrong = w; no_health = n; cur_health = 7'(hp);
    endtask

    task automatic idle(input int k, input int hp);
        repeat (k) cyc(0, 0, 0, 0, hp);
    endtask

    initial begin
        idle(3, 10);
        check("rst_hrst_n", 32'(health_reset_n), 32'd0);
        check("rst_rate",   32'(health_rate),    32'd100);
        check("rst_score",  32'(score),          32'd0);
        rst_n = 1'b1;
        idle(1, 10);

        // Session start: health held in reset through the CLEAR cycle.
        cyc(1, 0, 0, 0, 10);
        idle(1, 10);
        check("clear_hrst_n", 32'(health_reset_n), 32'd0);
        check("clear_playing", 32'(playing), 32'd0);
        idle(1, 10);
        check("play_hrst_n", 32'(health_reset_n), 32'd1);
        check("play_playing", 32'(playing), 32'd1);
        check("play_rate", 32'(health_rate), 32'd100);

        base_cnt = add_cnt;
        repeat (4) cyc(0, 1, 0, 0, 10);
        idle(2, 10);
        check("t2_adds",  32'(add_cnt - base_cnt), 32'd4);
        check("t2_score", 32'(score), 32'd4);
        check("t2_level", 32'(level), 32'd2);
        check("t2_rate",  32'(health_rate), 32'd80);

        cyc(0, 0, 0, 1, 10);
        idle(1, 10);
        check("t3_over", 32'(game_over), 32'd1);
        cyc(1, 0, 0, 0, 10);
        idle(2, 10);
        check("t3_restart_score", 32'(score), 32'd0);
        check("t3_restart_level", 32'(level), 32'd0);
        base_cnt = add_cnt;
        cyc(0, 1, 0, 0, 10);
        cyc(0, 0, 1, 0, 10);
        cyc(0, 1, 0, 0, 10);
        idle(1, 10);
        check("t3_score", 32'(score), 32'd2);
        check("t3_level", 32'(level), 32'd0);
        cyc(0, 1, 1, 0, 10);
        idle(1, 10);
        check("t3_both_score", 32'(score), 32'd2);
        check("t3_both_adds",  32'(add_cnt - base_cnt), 32'd2);

        base_cnt = add_cnt;
        repeat (20) cyc(0, 1, 0, 0, 22);
        idle(2, 22);
        check("t4_level", 32'(level), 32'd9);
        check("t4_rate",  32'(health_rate), 32'd40);
        check("t4_score", 32'(score), 32'd22);
        check("t4_adds",  32'(add_cnt - base_cnt), 32'd0);

        base_cnt = add_cnt;
        cyc(0, 1, 0, 1, 10);
        idle(1, 10);
        check("t5_over",    32'(game_over), 32'd1);
        check("t5_playing", 32'(playing), 32'd0);
        check("t5_score",   32'(score), 32'd22);
        repeat (3) cyc(0, 1, 0, 0, 10);
        idle(1, 10);
        check("t5_hold_score", 32'(score), 32'd22);
        check("t5_hold_level", 32'(level), 32'd9);
        check("t5_adds", 32'(add_cnt - base_cnt), 32'd0);
        cyc(1, 0, 0, 0, 10);
        idle(1, 10);
        check("t5_clear_hrst_n", 32'(health_reset_n), 32'd0);
        idle(1, 10);
        check("t5_play", 32'(playing), 32'd1);
        check("t5_play_score", 32'(score), 32'd0);

        repeat (6) cyc(0, 1, 0, 0, 10);
        idle(1, 10);
        check("t6_level", 32'(level), 32'd3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_hrst_n",   32'(health_reset_n), 32'd0);
        check("t6_playing",  32'(playing), 32'd0);
        check("t6_over",     32'(game_over), 32'd0);
        check("t6_add",      32'(add_health), 32'd0);
        check("t6_score",    32'(score), 32'd0);
        check("t6_level_rst", 32'(level), 32'd0);
        check("t6_rate",     32'(health_rate), 32'd100);
        idle(2, 10);
        rst_n = 1'b1;
        idle(2, 10);
        check("t6_idle_playing", 32'(playing), 32'd0);
        check("t6_idle_hrst_n",  32'(health_reset_n), 32'd0);

        repeat (3000) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 399) != 0);
            start = ($urandom_range(0, 19) == 0);
            correct = ($urandom_range(0, 2) == 0);
            wrong = ($urandom_range(0, 5) == 0);
            no_health = ($urandom_range(0, 59) == 0);
            cur_health = 7'($urandom_range(15, 30));
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/health_controller.md
# health_controller

Game-session controller that sequences the `health` block. It runs the IDLE/CLEAR/PLAY/OVER session FSM and drives health's synchronous reset. It converts correct-answer pulses into `add_health` pulses, capped at a maximum health. It tracks score, streak and level, and sets the health decay period (`health_rate`) from the level, so the game speeds up as the player advances.

## Interface
Parameters:
- `BASE_RATE`, default 27'd50_000_000: decay period at level 0, in clocks.
- `RATE_STEP`, default 27'd5_000_000: period reduction per level.
- `MIN_RATE`, default 27'd10_000_000: floor on the period.
- `LEVEL_UP`, default 5: consecutive correct answers needed per level.
- `MAX_LEVEL`, default 9: level saturation value, must fit in 4 bits.
- `MAX_HEALTH`, default 7'd99: no `add_health` pulse is issued at or above this value.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that starts a game.
- `correct`  in  1  one-cycle pulse for a correct answer.
- `wrong`  in  1  one-cycle pulse for a wrong answer.
- `current_health`  in  7  from health.
- `no_health`  in  1  from health.
- `health_reset_n`  out  1  drives health's `reset` input (active-low).
- `health_rate`  out  27  drives health's `health_rate` input.
- `add_health`  out  1  drives health's `add_health` input; one-cycle pulse.
- `score`  out  8  total correct answers this game; saturates at 255.
- `level`  out  4  current level, 0 to `MAX_LEVEL`.
- `playing`  out  1  high in PLAY.
- `game_over`  out  1  high in OVER.

## Operation
FSM states and transitions:
- IDLE: `health_reset_n` = 0. `start` -> CLEAR.
- CLEAR: exactly one cycle. `health_reset_n` = 0. Clears `score`, `level` and `streak`. Always -> PLAY.
- PLAY: `health_reset_n` = 1.
  - `no_health` -> OVER. This has priority over every other event in the same cycle.
  - `start` is ignored.
- OVER: `health_reset_n` = 1. `add_health` is never asserted. `score` and `level` hold for display. `start` -> CLEAR.

Answer handling (PLAY only, when `no_health` = 0):
- `correct` alone:
  - `score` += 1, saturating at 255.
  - `streak` += 1. When `streak` reaches `LEVEL_UP`, `streak` <- 0 and `level` += 1, saturating at `MAX_LEVEL`.
  - `add_health` pulses only if `current_health` < `MAX_HEALTH`. Score and streak update regardless of the cap.
- `wrong` alone: `streak` <- 0. No change to `score` or `level`.
- `correct` and `wrong` in the same cycle: both are ignored.
- Answer pulses are ignored in IDLE, CLEAR and OVER.

Rate rule:
- `health_rate` = max(`BASE_RATE` − `level`×`RATE_STEP`, `MIN_RATE`).
- Compute at 28 bits or wider so a negative intermediate cannot wrap.
- The output is registered and updates in the cycle after `level` changes.

Reset values:
- state IDLE, `health_reset_n` 0, `add_health` 0, `health_rate` `BASE_RATE`.
- `score` 0, `level` 0, internal `streak` 0.
- `playing` 0, `game_over` 0.

## Timing
- All outputs are registered.
- An input sampled at edge n takes effect on the outputs after edge n.
- `start` at edge n:
  - CLEAR after n, with `health_reset_n` low for one cycle.
  - PLAY after n+1, when health loads 20.
  - `playing` = 1 after n+1.
- `correct` at edge n: `add_health` high for the single cycle after n. `score` and `level` update at the same point. `health_rate` follows one cycle later.
- Back-to-back `correct` pulses produce back-to-back `add_health` pulses.
- `no_health` at edge n: OVER after n, `game_over` = 1. Any `correct` sampled at edge n is dropped.
- Asynchronous reset mid-game: outputs go to their reset values immediately. `health_reset_n` = 0 holds health in reset.
- `add_health` is never high while `health_reset_n` = 0.

## Structure
- Shared package `health_ctrl_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, CLEAR, PLAY, OVER} hc_state_t`;
  - the default rate constants;
  - `HEALTH_W` = 7 and `RATE_W` = 27.
- One sub-module, `health_rate_calc`: combinational level-to-rate with the floor, taking the `BASE_RATE`, `RATE_STEP` and `MIN_RATE` parameters.
- The FSM, counters and output registers live in `health_controller`.

## Test plan
Simulation parameters: `BASE_RATE`=100, `RATE_STEP`=10, `MIN_RATE`=40, `LEVEL_UP`=2, `MAX_LEVEL`=9, `MAX_HEALTH`=22.

1. Reset, then `start` at edge n -> `health_reset_n` = 0 through edge n+1 and 1 afterwards. `playing` = 1 after n+1. `health_rate` = 100.
2. 4 `correct` pulses in PLAY -> 4 `add_health` pulses, `score` = 4, `level` = 2, `health_rate` = 80.
3. `correct`, `wrong`, `correct` -> `score` = 2, `level` = 0. `correct` and `wrong` in the same cycle -> no change and no `add_health`.
4. 20 `correct` pulses -> `level` saturates at 9 and `health_rate` = 40, the floor. With `current_health` = 22 there is no `add_health`, but `score` still increments.
5. `no_health` = 1 in the same cycle as `correct` -> OVER, `game_over` = 1, no `add_health`. Later answers are ignored. `start` -> CLEAR, then PLAY with `score` = 0.
6. Assert `reset` mid-PLAY with `level` = 3 -> all outputs return to reset values asynchronously, and state is IDLE after release.
